adc_frame_controller: RTL
=========================

// Module: adc_frame_controller
// PURPOSE
//   SPI frame controller for the ADC128S022 8-channel 12-bit ADC. It consumes the
//   divided ADC clock from the frequency-scaling stage (adc_clk_in, same clk_50M domain)
//   and drives CS_N/SCLK/DIN. It shifts in one 12-bit conversion per frame and hands the
//   result to the RISC-V CPU / algorithm side with a one-cycle valid strobe.
// PARAMETERS
//   FRAME_LEN   16  SCLK cycles per frame (bit_cnt 0..FRAME_LEN-1)
//   DATA_W      12  conversion result width
//   LEAD_ZEROS  4   leading DOUT bits discarded (bit_cnt 0..3)
//   CH_W        3   channel address width
// PORTS
//   clk_50M     in   1       50 MHz system clock; all logic on posedge
//   rst_n       in   1       asynchronous active-low reset
//   adc_clk_in  in   1       divided clock from frequency scaler, registered in clk_50M domain
//   start       in   1       request one conversion; level or pulse, sampled every clk_50M
//   cont_en     in   1       1 = back-to-back frames without start
//   channel     in   CH_W    channel to convert; latched at frame start
//   busy        out  1       1 from frame start until cs_n returns high
//   adc_cs_n    out  1       ADC chip select, active low
//   adc_sck     out  1       ADC serial clock, idles high
//   adc_din     out  1       ADC address bit, changes only on SCLK falling edge
//   adc_dout    in   1       ADC serial data, sampled on SCLK rising edge
//   data_out    out  DATA_W  last completed conversion, held until next frame completes
//   data_ch     out  CH_W    channel of data_out
//   data_valid  out  1       one-cycle pulse when data_out/data_ch update
// BEHAVIOUR
//   Reset (async, immediate, including mid-frame): adc_cs_n=1, adc_sck=1, adc_din=0,
//     busy=0, data_valid=0, data_out=0, data_ch=0, bit_cnt=0, pend=0, gap_ok=1, state=IDLE.
//     A partial frame is discarded; no data_valid is issued.
//   Edge detect: clk_d <= adc_clk_in; rise_tick = adc_clk_in & ~clk_d; fall_tick = ~adc_clk_in & clk_d.
//   pend: set when start=1 and state=IDLE; cleared at frame start. start is ignored while busy.
//   FSM IDLE:
//     - rise_tick sets gap_ok=1. This guarantees a CS high time of at least one full SCLK period.
//     - fall_tick & gap_ok & (pend|cont_en) -> FRAME:
//       cs_n<=0, sck<=0, bit_cnt<=0, din<=0, ch_q<=channel, busy<=1, pend<=0, shift<=0.
//   FSM FRAME:
//     - rise_tick: sck<=1. If bit_cnt>=LEAD_ZEROS, shift <= {shift[DATA_W-2:0], adc_dout}.
//     - fall_tick & bit_cnt<FRAME_LEN-1: bit_cnt<=bit_cnt+1, sck<=0, din<=addr bit for new count.
//       Addr bit: bit_cnt 2,3,4 -> ch_q[2],ch_q[1],ch_q[0]; all other counts -> 0.
//     - fall_tick & bit_cnt==FRAME_LEN-1 -> IDLE: cs_n<=1, sck<=1, din<=0, busy<=0, gap_ok<=0,
//       data_out<=shift, data_ch<=ch_q, data_valid<=1 (exactly one clk_50M cycle).
//   Timing and latency:
//     - adc_sck lags adc_clk_in by one clk_50M cycle during a frame.
//     - Frame = 16 SCLK periods (256 clk_50M cycles at SCALE=3).
//     - Start-to-start in cont_en mode = 17 SCLK periods.
//   Boundaries:
//     - start asserted on the same cycle data_valid pulses is accepted (state is IDLE).
//       That frame begins only after the gap has elapsed.
//     - cont_en deasserted mid-frame: the current frame completes and no new frame starts.
//     - channel changes mid-frame have no effect (ch_q is used).
//     - adc_clk_in stalled: FSM holds state indefinitely; no timeout.
//     - Counter and shift register never wrap inside a frame.
// TESTING
//   1 Reset, no start, 40 SCLK periods -> cs_n=1, sck=1, data_valid never asserted, busy=0.
//   2 start pulse, channel=5, ADC model returns 0xA5C -> din bits 2..4 = 1,0,1;
//     16 SCLK falls; data_valid once, data_out=0xA5C, data_ch=5.
//   3 cont_en=1, channel 3 then 6 -> two back-to-back frames 17 SCLK periods apart;
//     cs_n high for >=1 SCLK period between them; data_ch=3 then 6.
//   4 start held high through a frame and 0xFFF/0x000 patterns -> one frame per IDLE entry;
//     leading-zero bits are not captured; data_out=0xFFF then 0x000.
//   5 rst_n low at bit_cnt=9 -> cs_n=1 and sck=1 within the same cycle, no data_valid;
//     the next start yields a full, correct frame.
//   6 channel toggled at bit_cnt=6, start pulse during busy -> result tagged with the
//     original channel; no extra frame follows.

Source files
------------

// File: rtl/adc_frame_controller.sv
// SPI frame controller for the ADC128S022: generates CS_N/SCLK/DIN from the divided
// ADC clock, shifts in one 12-bit conversion per frame and publishes it with a valid strobe.
module adc_frame_controller #(
    parameter int FRAME_LEN  = 16,
    parameter int DATA_W     = 12,
    parameter int LEAD_ZEROS = 4,
    parameter int CH_W       = 3
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic              adc_clk_in,
    input  logic              start,
    input  logic              cont_en,
    input  logic [CH_W-1:0]   channel,
    output logic              busy,
    output logic              adc_cs_n,
    output logic              adc_sck,
    output logic              adc_din,
    input  logic              adc_dout,
    output logic [DATA_W-1:0] data_out,
    output logic [CH_W-1:0]   data_ch,
    output logic              data_valid
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LEAD_CNT = CNT_W'(LEAD_ZEROS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t              state_q, state_d;
    logic                clk_d_q;
    logic                cs_n_q, cs_n_d;
    logic                sck_q, sck_d;
    logic                din_q, din_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                pend_q, pend_d;
    logic                gap_ok_q, gap_ok_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [CH_W-1:0]     data_ch_q, data_ch_d;

    logic                rise_tick;
    logic                fall_tick;
    logic [CNT_W-1:0]    bit_cnt_inc;
    logic [FRAME_LEN-1:0] addr_map;

    assign rise_tick   = adc_clk_in & ~clk_d_q;
    assign fall_tick   = ~adc_clk_in & clk_d_q;
    assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);

    // DIN value for each bit position: channel address MSB-first in slots 2.., zero elsewhere.
    for (genvar gi = 0; gi < FRAME_LEN; gi++) begin : g_addr
        if (gi >= 2 && gi < 2 + CH_W) begin : g_ch
            assign addr_map[gi] = ch_q[CH_W + 1 - gi];
        end else begin : g_zero
            assign addr_map[gi] = 1'b0;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clk_d_q    <= 1'b0;
            cs_n_q     <= 1'b1;
            sck_q      <= 1'b1;
            din_q      <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            pend_q     <= 1'b0;
            gap_ok_q   <= 1'b1;
            bit_cnt_q  <= '0;
            ch_q       <= '0;
            shift_q    <= '0;
            data_out_q <= '0;
            data_ch_q  <= '0;
        end else begin
            state_q    <= state_d;
            clk_d_q    <= adc_clk_in;
            cs_n_q     <= cs_n_d;
            sck_q      <= sck_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            pend_q     <= pend_d;
            gap_ok_q   <= gap_ok_d;
            bit_cnt_q  <= bit_cnt_d;
            ch_q       <= ch_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            data_ch_q  <= data_ch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cs_n_d     = cs_n_q;
        sck_d      = sck_q;
        din_d      = din_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        pend_d     = pend_q;
        gap_ok_d   = gap_ok_q;
        bit_cnt_d  = bit_cnt_q;
        ch_d       = ch_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        data_ch_d  = data_ch_q;

        if (start && state_q == IDLE) begin
            pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // A rising edge seen while CS is high means a full SCLK period of deselect is guaranteed.
                if (rise_tick) begin
                    gap_ok_d = 1'b1;
                end
                if (fall_tick && gap_ok_q && (pend_q || cont_en)) begin
                    state_d   = FRAME;
                    cs_n_d    = 1'b0;
                    sck_d     = 1'b0;
                    bit_cnt_d = '0;
                    din_d     = 1'b0;
                    ch_d      = channel;
                    busy_d    = 1'b1;
                    pend_d    = 1'b0;
                    shift_d   = '0;
                end
            end
            FRAME: begin
                if (rise_tick) begin
                    sck_d = 1'b1;
                    if (bit_cnt_q >= LEAD_CNT) begin
                        shift_d = {shift_q[DATA_W-2:0], adc_dout};
                    end
                end else if (fall_tick) begin
                    if (bit_cnt_q != LAST_CNT) begin
                        bit_cnt_d = bit_cnt_inc;
                        sck_d     = 1'b0;
                        din_d     = addr_map[bit_cnt_inc];
                    end else begin
                        state_d    = IDLE;
                        cs_n_d     = 1'b1;
                        sck_d      = 1'b1;
                        din_d      = 1'b0;
                        busy_d     = 1'b0;
                        gap_ok_d   = 1'b0;
                        data_out_d = shift_q;
                        data_ch_d  = ch_q;
                        valid_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = busy_q;
    assign adc_cs_n   = cs_n_q;
    assign adc_sck    = sck_q;
    assign adc_din    = din_q;
    assign data_out   = data_out_q;
    assign data_ch    = data_ch_q;
    assign data_valid = valid_q;

endmodule
